// File: rtl/bz_link_flit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : bz_link_flit_deserializer
// Brief    : Assembles header + N_DATA link flits into one routed packet;
//            drops negative routes and aborts stalled packets via watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module bz_link_flit_deserializer #(
  parameter int FLIT_W  = 11,
  parameter int N_DATA  = 3,
  parameter int ROUTE_W = 6,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FLIT_W-1:0]         in_flit,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ROUTE_W-1:0]        out_route,
  output logic [N_DATA*FLIT_W-1:0]  out_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          drop_count,
  output logic [CNT_W-1:0]          timeout_count,
  output logic                      busy
);

  localparam int c_IDX_W = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam int c_WD_W  = $clog2(TIMEOUT);
  localparam int c_PAY_W = N_DATA * FLIT_W;

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_DATA - 1);
  localparam logic [c_WD_W-1:0]  c_WD_MAX   = c_WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

  typedef enum logic [0:0] {
    ST_HDR  = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [c_WD_W-1:0]    r_wd, w_wd_nxt;
  logic [ROUTE_W-1:0]   r_route;
  logic [ROUTE_W-1:0]   r_out_route;
  logic [c_PAY_W-1:0]   r_out_payload;
  logic                 r_out_valid;
  logic [CNT_W-1:0]     r_drop_count;
  logic [CNT_W-1:0]     r_timeout_count;
  logic [c_PAY_W-1:0]   w_payload_fin;

  logic w_last, w_neg, w_in_ready, w_accept, w_expire;
  logic w_fin_ok, w_fin_drop;

  // Only the last data flit of a forwarded packet can be stalled by the output.
  always_comb begin
    w_last     = (r_state == ST_DATA) && (r_idx == c_LAST_IDX);
    w_neg      = r_route[ROUTE_W-1];
    w_in_ready = !(w_last && !w_neg) || !r_out_valid || out_ready;
    w_accept   = in_valid && w_in_ready;
    w_expire   = (r_state == ST_DATA) && (r_wd == c_WD_MAX) && !w_accept;
    w_fin_ok   = w_last && w_accept && !w_neg;
    w_fin_drop = w_last && w_accept && w_neg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HDR;
      r_idx   <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wd_nxt    = r_wd;
    case (r_state)
      ST_HDR: begin
        w_wd_nxt = '0;
        if (w_accept) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_wd_nxt = '0;
          if (w_last) begin
            w_state_nxt = ST_HDR;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (w_expire) begin
          w_state_nxt = ST_HDR;
          w_wd_nxt    = '0;
        end else if (!in_valid) begin
          // Backpressured cycles (valid but not ready) hold the count.
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HDR;
        w_wd_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_route <= '0;
    end else if (w_accept && (r_state == ST_HDR)) begin
      r_route <= in_flit[FLIT_W-1 -: ROUTE_W];
    end
  end

  // The last data flit goes straight from the pins into the output register.
  generate
    if (N_DATA > 1) begin : g_multi
      logic [(N_DATA-1)*FLIT_W-1:0] r_asm;
      for (genvar i = 0; i < N_DATA - 1; i++) begin : g_slice
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            r_asm[i*FLIT_W +: FLIT_W] <= '0;
          end else if (w_accept && (r_state == ST_DATA) && (r_idx == c_IDX_W'(i))) begin
            r_asm[i*FLIT_W +: FLIT_W] <= in_flit;
          end
        end
      end
      assign w_payload_fin = {in_flit, r_asm};
    end else begin : g_single
      assign w_payload_fin = in_flit;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_route   <= '0;
      r_out_payload <= '0;
    end else if (w_fin_ok) begin
      r_out_valid   <= 1'b1;
      r_out_route   <= r_route;
      r_out_payload <= w_payload_fin;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count    <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_fin_drop && (r_drop_count != c_CNT_MAX)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
      if (w_expire && (r_timeout_count != c_CNT_MAX)) begin
        r_timeout_count <= r_timeout_count + 1'b1;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_route     = r_out_route;
  assign out_payload   = r_out_payload;
  assign out_valid     = r_out_valid;
  assign drop_count    = r_drop_count;
  assign timeout_count = r_timeout_count;
  assign busy          = (r_state != ST_HDR);

endmodule
`default_nettype wire

// File: tb/tb_bz_link_flit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bz_link_flit_deserializer
// Brief    : Scoreboard bench for the link flit deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bz_link_flit_deserializer;

  localparam int FLIT_W  = 11;
  localparam int N_DATA  = 3;
  localparam int ROUTE_W = 6;
  localparam int TIMEOUT = 1024;
  localparam int CNT_W   = 16;
  localparam int PAY_W   = N_DATA * FLIT_W;

  typedef struct packed {
    logic [ROUTE_W-1:0] route;
    logic [PAY_W-1:0]   pay;
  } pkt_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [FLIT_W-1:0]  in_flit;
  logic               in_valid;
  logic               in_ready;
  logic [ROUTE_W-1:0] out_route;
  logic [PAY_W-1:0]   out_payload;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W-1:0]   drop_count;
  logic [CNT_W-1:0]   timeout_count;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_ready_en = 1'b0;

  pkt_t              sb[$];
  logic [FLIT_W-1:0] cur[$];
  int                idle_cnt = 0;
  bit                model_full = 1'b0;
  int                exp_drop = 0;
  int                exp_to   = 0;

  bz_link_flit_deserializer #(
    .FLIT_W(FLIT_W), .N_DATA(N_DATA), .ROUTE_W(ROUTE_W),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .out_route(out_route), .out_payload(out_payload),
    .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count),
    .timeout_count(timeout_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: tracks the packet in flight as a flit list and predicts
  // handshakes, counters and emitted packets from the protocol rules.
  always @(negedge clk) begin
    if (reset) begin
      cur.delete();
      sb.delete();
      idle_cnt   = 0;
      model_full = 1'b0;
      exp_drop   = 0;
      exp_to     = 0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_drop", 64'(drop_count), 64'd0);
      check("rst_timeout", 64'(timeout_count), 64'd0);
    end else begin
      logic [FLIT_W-1:0] hdr;
      logic [PAY_W-1:0]  pay;
      bit exp_rdy, acc, fin_ok;
      hdr = (cur.size() > 0) ? cur[0] : '0;
      exp_rdy = !(cur.size() == N_DATA && !hdr[FLIT_W-1] && model_full && !out_ready);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(model_full));
      check("busy", 64'(busy), 64'(cur.size() != 0));
      check("drop_count", 64'(drop_count), 64'(exp_drop));
      check("timeout_count", 64'(timeout_count), 64'(exp_to));
      acc    = in_valid && exp_rdy;
      fin_ok = 1'b0;
      if (acc) begin
        cur.push_back(in_flit);
        idle_cnt = 0;
        if (cur.size() == N_DATA + 1) begin
          hdr = cur[0];
          if (hdr[FLIT_W-1]) begin
            exp_drop = (exp_drop < 2**CNT_W - 1) ? exp_drop + 1 : exp_drop;
          end else begin
            for (int i = 0; i < N_DATA; i++) pay[i*FLIT_W +: FLIT_W] = cur[i+1];
            sb.push_back('{route: hdr[FLIT_W-1 -: ROUTE_W], pay: pay});
            fin_ok = 1'b1;
          end
          cur.delete();
        end
      end else if (cur.size() > 0) begin
        if (idle_cnt == TIMEOUT - 1) begin
          cur.delete();
          idle_cnt = 0;
          exp_to = (exp_to < 2**CNT_W - 1) ? exp_to + 1 : exp_to;
        end else if (!in_valid) begin
          idle_cnt++;
        end
      end
      if (fin_ok) model_full = 1'b1;
      else if (out_ready) model_full = 1'b0;
    end
  end

  // Monitor: every presented packet must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_packet: got route %0h payload %0h expected none", out_route, out_payload);
      end else begin
        check("out_route", 64'(out_route), 64'(sb[0].route));
        check("out_payload", 64'(out_payload), 64'(sb[0].pay));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rand_ready_en) begin
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send_flit(input logic [FLIT_W-1:0] f);
    int n = 0;
    in_flit  = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected accept", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [FLIT_W-1:0] h, input logic [FLIT_W-1:0] d0,
                          input logic [FLIT_W-1:0] d1, input logic [FLIT_W-1:0] d2);
    send_flit(h);
    send_flit(d0);
    send_flit(d1);
    send_flit(d2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_flit   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Basic packet: route 1, payload {0x01F,0x007,0x001}
    send_pkt(11'h020, 11'h001, 11'h007, 11'h01F);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_route", 64'(out_route), 64'd1);
    check("t1_payload", 64'(out_payload), 64'h07C03801);
    check("t1_drop", 64'(drop_count), 64'd0);

    // Negative route dropped
    send_pkt(11'h400, 11'h123, 11'h456, 11'h789);
    @(posedge clk); #1;
    check("t2_drop", 64'(drop_count), 64'd1);
    check("t2_no_valid", 64'(out_valid), 64'd0);

    // Output held: second packet's last flit stalls until release
    out_ready = 1'b0;
    send_pkt(11'h060, 11'h111, 11'h222, 11'h333);
    send_flit(11'h0A0);
    send_flit(11'h444);
    send_flit(11'h555);
    fork
      send_flit(11'h666);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t3_stall_ready", 64'(in_ready), 64'd0);
          check("t3_hold_route", 64'(out_route), 64'd3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check("t3_b2b_valid", 64'(out_valid), 64'd1);
    check("t3_b2b_route", 64'(out_route), 64'd5);
    check("t3_b2b_payload", 64'(out_payload), 64'({11'h666, 11'h555, 11'h444}));

    // Watchdog abort after TIMEOUT idle cycles
    send_flit(11'h0E0);
    send_flit(11'h0AA);
    idle(TIMEOUT - 1);
    check("t4_busy_before", 64'(busy), 64'd1);
    idle(1);
    check("t4_busy_after", 64'(busy), 64'd0);
    check("t4_timeout", 64'(timeout_count), 64'd1);
    send_pkt(11'h0C0, 11'h00A, 11'h00B, 11'h00C);

    // Flit on the expiry cycle wins
    send_flit(11'h100);
    send_flit(11'h0BB);
    idle(TIMEOUT - 1);
    send_flit(11'h0CC);
    check("t5_timeout", 64'(timeout_count), 64'd1);
    check("t5_busy", 64'(busy), 64'd1);
    send_flit(11'h0DD);
    idle(2);

    // Asynchronous reset mid-packet
    send_flit(11'h120);
    send_flit(11'h0EE);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_drop", 64'(drop_count), 64'd0);
    check("t6_timeout", 64'(timeout_count), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_pkt(11'h140, 11'h7FF, 11'h000, 11'h555);
    check("t6_route", 64'(out_route), 64'd10);
    check("t6_payload", 64'(out_payload), 64'({11'h555, 11'h000, 11'h7FF}));

    // Randomized traffic with random gaps and downstream stalls
    rand_ready_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      logic [FLIT_W-1:0] h;
      h = FLIT_W'($urandom);
      h[FLIT_W-1] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k <= N_DATA; k++) begin
        send_flit((k == 0) ? h : FLIT_W'($urandom));
        if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
      end
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bz_link_flit_deserializer.md
Name: bz_link_flit_deserializer

Overview:
- Receive-side stage for the inter-board link. Sits between the top_in/top_valid_in/top_ready_in link pins (after clock-domain crossing) and the host core's upstream packet router.
- Collects one header flit plus N_DATA data flits of FLIT_W bits each and emits one assembled packet (route, payload) on a valid/ready interface.
- Discards negative-route packets and aborts stalled partial packets via a watchdog; both events are counted.

Parameters:
- FLIT_W, 11, link flit width
- N_DATA, 3, data flits per packet (>=1)
- ROUTE_W, 6, route field width; header bits [FLIT_W-1 -: ROUTE_W]
- TIMEOUT, 1024, idle cycles mid-packet before abort (>=2)
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- in_flit  in  FLIT_W  link flit
- in_valid  in  1  flit valid
- in_ready  out  1  flit accepted when in_valid && in_ready
- out_route  out  ROUTE_W  header route field (two's complement)
- out_payload  out  N_DATA*FLIT_W  data flits; first data flit in LSBs
- out_valid  out  1  packet valid
- out_ready  in  1  downstream accepts
- drop_count  out  CNT_W  negative-route packets discarded, saturating
- timeout_count  out  CNT_W  partial packets aborted, saturating
- busy  out  1  high while a partial packet is held (state != HDR)

Behaviour:
- Reset:
  - Async assertion forces state=HDR, out_valid=0, out_route=0, out_payload=0, counters=0, busy=0, watchdog=0.
  - A partial packet in progress is lost and is not counted.
  - in_ready=1 after release.
- States:
  - HDR: accept flit, latch route = flit[FLIT_W-1 -: ROUTE_W]; header low bits are ignored. Go to DATA with k=0.
  - DATA(k): accept flit into assembly slice k. If k < N_DATA-1, k++. If k = N_DATA-1 (last flit), finalise and return to HDR.
- Last-flit backpressure:
  - In DATA(N_DATA-1) with a non-negative route: in_ready = !out_valid || out_ready.
  - With a negative route: in_ready=1.
  - In all other states in_ready=1.
- Finalise (non-negative route): the output register loads route and payload. out_valid=1 from the cycle after the last flit is accepted, i.e. latency is 1 cycle from last flit to out_valid.
- Finalise (negative route, route MSB=1):
  - No output.
  - drop_count increments, saturating at 2^CNT_W-1.
- Output register:
  - out_valid holds with data stable until out_ready.
  - out_valid && out_ready clears out_valid, unless a new packet finalises in the same cycle; in that case the register reloads and out_valid stays 1 (back-to-back, no bubble).
- Watchdog:
  - In DATA states, the counter increments each cycle in_valid=0.
  - It clears on any accepted flit and on entry to HDR.
  - Cycles with in_valid=1 && in_ready=0 (backpressure) hold the counter.
  - When the count reaches TIMEOUT-1 and no flit is accepted that cycle: discard the partial packet, state goes to HDR, timeout_count increments (saturating).
  - A flit accepted in the same cycle as expiry wins: no abort, the counter clears.
- Back-to-back packets are accepted with no idle cycles when out_ready=1. Sustained throughput is 1 packet per N_DATA+1 cycles.
- The output register is independent of assembly: a new header may be accepted while out_valid is held.

Test Plan:
1. After reset, flits 0x020, 0x001, 0x007, 0x01F with out_ready=1 -> out_valid high 1 cycle after the 4th flit; out_route=1, out_payload=0x07C03801; drop_count=0.
2. Header 0x400 (route=-32), then 3 data flits -> no out_valid; drop_count=1; in_ready stays 1 throughout.
3. Hold out_ready=0, send two packets -> first packet held stable; second packet's last flit sees in_ready=0. Raise out_ready -> first packet consumed, second loads in the same cycle with out_valid staying high.
4. Header plus 1 data flit, then in_valid=0 for TIMEOUT cycles -> busy drops, timeout_count=1. The next valid packet is assembled correctly.
5. Send the expected flit exactly on the expiry cycle -> no abort, timeout_count unchanged.
6. Assert reset mid-packet after 2 flits -> out_valid=0, busy=0, counters=0 immediately. The following full packet is decoded correctly.
